piso_tx_ctrl: RTL

PISO_TX_CTRL -- requirements
Module: piso_tx_ctrl

---
 rtl/piso_pkg.sv | 24 ++
 rtl/piso.sv | 30 +++
 rtl/piso_tx_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared constants and FSM state encoding for the piso_tx_ctrl serial transmitter.
// The PARITY encoding exists only when PISO_TX_CTRL_PARITY_EN is defined.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_GAPW   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SHIFT = ST_SHIFT,
    GAPW  = ST_GAPW
`ifdef PISO_TX_CTRL_PARITY_EN
    ,
    PARITY = ST_PARITY
`endif
  } state_t;

endpackage

// File: rtl/piso.sv
// Parallel-in serial-out shift register, MSB first; latch loads din, otherwise
// the register shifts left each cycle and ser fills the LSB.
module piso
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             latch,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             ser,
  output logic             dout
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (latch) begin
      sr_q <= din;
    end else begin
      sr_q <= {sr_q[WIDTH-2:0], ser};
    end
  end

  assign dout = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame controller around a piso shifter: accept a word, send it MSB first, then idle GAP cycles.
// Define PISO_TX_CTRL_PARITY_EN to append an even parity bit after the data bits.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam state_t POST_DATA = (GAP > 0) ? GAPW : IDLE;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [GAP_W-1:0] gap_q;
  logic [WIDTH-1:0] hold_q;
  logic             latch;
  logic             piso_dout;
  logic             last_bit;

  assign last_bit = (cnt_q == LAST_BIT);

  piso #(.WIDTH(WIDTH)) u_piso (
    .clk  (clk),
    .latch(latch),
    .rst  (rst),
    .din  (hold_q),
    .ser  (1'b0),
    .dout (piso_dout)
  );

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
    end else begin
      if (state_q == IDLE && din_valid) begin
        hold_q <= din;
      end
      // Both counters clear whenever their state is not active, so each starts at 0.
      cnt_q <= (state_q == SHIFT) ? cnt_q + CNT_W'(1) : '0;
      gap_q <= (state_q == GAPW) ? gap_q + GAP_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (din_valid) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef PISO_TX_CTRL_PARITY_EN
          state_d = PARITY;
`else
          state_d = POST_DATA;
`endif
        end
      end
`ifdef PISO_TX_CTRL_PARITY_EN
      PARITY: state_d = POST_DATA;
`endif
      GAPW:  if (gap_q == LAST_GAP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    din_ready = 1'b0;
    busy      = 1'b1;
    latch     = 1'b0;
    frame     = 1'b0;
    dout      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        busy      = 1'b0;
      end
      LOAD: latch = 1'b1;
      SHIFT: begin
        frame = 1'b1;
        dout  = piso_dout;
`ifndef PISO_TX_CTRL_PARITY_EN
        done  = last_bit;
`endif
      end
`ifdef PISO_TX_CTRL_PARITY_EN
      PARITY: begin
        frame = 1'b1;
        dout  = ^hold_q;
        done  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
